regfile_sb: RTL

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb_if.sv | 39 +++
 rtl/regfile_sb.sv | 102 ++++++++++
 2 files changed

// File: rtl/regfile_sb_if.sv
// Register-file bus: two write ports, two combinational read ports, and the
// issue/flush controls of the per-register busy scoreboard.
// There is no valid/ready handshake: wenN and iss_en are one-cycle
// strobes sampled on every rising clock edge.
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              wen0;
    logic [ADDR_W-1:0] waddr0;
    logic [DATA_W-1:0] wdata0;
    logic              wen1;
    logic [ADDR_W-1:0] waddr1;
    logic [DATA_W-1:0] wdata1;
    logic [ADDR_W-1:0] raddr0;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              rbusy0;
    logic              rbusy1;
    logic              iss_en;
    logic [ADDR_W-1:0] iss_addr;
    logic              flush;
    logic [ADDR_W:0]   busy_cnt;

    // Side that drives the writes, reads, issues and flushes.
    modport master (
        output wen0, waddr0, wdata0, wen1, waddr1, wdata1,
        output raddr0, raddr1, iss_en, iss_addr, flush,
        input  rdata0, rdata1, rbusy0, rbusy1, busy_cnt
    );

    // Register-file side.
    modport slave (
        input  wen0, waddr0, wdata0, wen1, waddr1, wdata1,
        input  raddr0, raddr1, iss_en, iss_addr, flush,
        output rdata0, rdata1, rbusy0, rbusy1, busy_cnt
    );
endinterface

// File: rtl/regfile_sb.sv
// Dual-write, dual-read register file with a busy-bit scoreboard.
// Reads are combinational and bypass same-cycle writes (port 1 wins).
// A busy bit is set by issue and cleared by a write to that register.
// Issue beats a same-cycle write, and flush beats everything.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    regfile_sb_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [ADDR_W:0]   busy_cnt_q;
    logic [ADDR_W:0]   busy_cnt_d;

    // Register 0 is hardwired when ZERO_REG is set, so writes to it and
    // issues to it are qualified out here.
    logic wr0_ok;
    logic wr1_ok;
    logic iss_ok;
    assign wr0_ok = bus.wen0   && !((ZERO_REG != 0) && (bus.waddr0   == '0));
    assign wr1_ok = bus.wen1   && !((ZERO_REG != 0) && (bus.waddr1   == '0));
    assign iss_ok = bus.iss_en && !((ZERO_REG != 0) && (bus.iss_addr == '0));

    // Next data, busy bits and busy count.
    // Port 1 is applied after port 0 so that it wins a same-address tie.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr0_ok) regs_d[bus.waddr0] = bus.wdata0;
        if (wr1_ok) regs_d[bus.waddr1] = bus.wdata1;

        busy_d = busy_q;
        if (bus.wen0) busy_d[bus.waddr0] = 1'b0;
        if (bus.wen1) busy_d[bus.waddr1] = 1'b0;
        if (iss_ok)   busy_d[bus.iss_addr] = 1'b1;
        if (bus.flush) busy_d = '0;

        busy_cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_cnt_d = busy_cnt_d + (ADDR_W+1)'(busy_d[i]);
        end
    end

    // State registers; reset clears data, busy bits and count at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    logic [ADDR_W-1:0] raddr [2];
    logic [DATA_W-1:0] rdata [2];
    logic              rbusy [2];
    assign raddr[0] = bus.raddr0;
    assign raddr[1] = bus.raddr1;

    // Read ports: zero register first, then write bypass, then storage.
    // A same-cycle write hides the busy bit; a same-cycle issue does not show.
    for (genvar p = 0; p < 2; p++) begin : g_rd
        always_comb begin
            rdata[p] = regs_q[raddr[p]];
            rbusy[p] = busy_q[raddr[p]];
            if (bus.wen0 && (bus.waddr0 == raddr[p])) begin
                rdata[p] = bus.wdata0;
                rbusy[p] = 1'b0;
            end
            if (bus.wen1 && (bus.waddr1 == raddr[p])) begin
                rdata[p] = bus.wdata1;
                rbusy[p] = 1'b0;
            end
            if ((ZERO_REG != 0) && (raddr[p] == '0)) begin
                rdata[p] = '0;
                rbusy[p] = 1'b0;
            end
        end
    end

    assign bus.rdata0   = rdata[0];
    assign bus.rdata1   = rdata[1];
    assign bus.rbusy0   = rbusy[0];
    assign bus.rbusy1   = rbusy[1];
    assign bus.busy_cnt = busy_cnt_q;
endmodule
